hamming_corrector: RTL

- Downstream stage of the mod-2 syndrome multiplier in the Hamming error-correction demo.
- Accepts a received codeword plus its syndrome, flips the single bit the syndrome points to, and extracts the data bits.
- Registered valid/ready pipeline stage with one output register and full-throughput back-pressure. Feeds the data sink.

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_corrector_bit_flip.sv | 18 +
 rtl/hamming_corrector.sv | 111 +++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, types and helpers for the Hamming single-error corrector.
package hamming_pkg;

  localparam int unsigned COLS_DEF = 7;
  localparam int unsigned ROWS_DEF = 3;
  localparam int unsigned DATA_DEF = COLS_DEF - ROWS_DEF;

  // Upper bound on codeword width handled by the generic helpers below
  localparam int unsigned MAX_COLS = 32;
  localparam int unsigned IDX_W    = $clog2(MAX_COLS);

  typedef struct packed {
    logic [COLS_DEF-1:0] code;
    logic [DATA_DEF-1:0] data;
    logic                err;
    logic                uncorr;
  } hamming_rec_t;

  // Column i is a check bit when its syndrome value i+1 is a power of two
  function automatic logic is_parity_pos(input int unsigned i);
    return ((i + 1) & i) == 0;
  endfunction

  // Packs the non-check bits of the first cols bits of code, ascending, into the LSBs
  function automatic logic [MAX_COLS-1:0] extract_data(input logic [MAX_COLS-1:0] code,
                                                        input int unsigned cols);
    logic [MAX_COLS-1:0] data;
    logic [IDX_W-1:0]    k;
    data = '0;
    k    = '0;
    for (int unsigned i = 0; i < MAX_COLS; i++) begin
      if (i < cols && !is_parity_pos(i)) begin
        data[k] = code[IDX_W'(i)];
        k       = k + IDX_W'(1);
      end
    end
    return data;
  endfunction

endpackage

// File: rtl/hamming_corrector_bit_flip.sv
// Syndrome decoder: one-hot flip mask for the erroneous column plus out-of-range flag.
module hamming_bit_flip #(
  parameter int unsigned COLS = 7,
  parameter int unsigned ROWS = 3
) (
  input  logic [ROWS-1:0] syn,
  output logic [COLS-1:0] flip_mask_c,
  output logic            uncorr_c
);

  // Column i carries check-matrix value i+1, so it flips when the syndrome equals it
  for (genvar i = 0; i < COLS; i++) begin : g_col
    assign flip_mask_c[i] = (syn == ROWS'(i + 1));
  end

  assign uncorr_c = 32'(syn) > COLS;

endmodule

// File: rtl/hamming_corrector.sv
// Single-error Hamming corrector with one registered valid/ready output stage.
// Define HAMMING_ERR_CNT_EN to build the saturating corrected-word counter.
module hamming_corrector
  import hamming_pkg::*;
#(
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned DATA_W = COLS - ROWS,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COLS-1:0]   in_code,
  input  logic [ROWS-1:0]   in_syn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COLS-1:0]   out_code,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              out_uncorr,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef struct packed {
    logic [COLS-1:0]   code;
    logic [DATA_W-1:0] data;
    logic              err;
    logic              uncorr;
  } rec_t;

  logic [COLS-1:0] flip_mask;
  logic [COLS-1:0] code_fix;
  logic            uncorr;
  logic            xfer;
  logic            corrected;

  logic out_valid_q, out_valid_d;
  rec_t out_rec_q,   out_rec_d;

  hamming_bit_flip #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_bit_flip (
    .syn        (in_syn),
    .flip_mask_c(flip_mask),
    .uncorr_c   (uncorr)
  );

  // Ready whenever the output register is empty or being drained this cycle
  assign in_ready  = !out_valid_q || out_ready;
  assign xfer      = in_valid && in_ready;
  assign code_fix  = in_code ^ flip_mask;
  assign corrected = |flip_mask;

  always_comb begin
    out_valid_d = out_valid_q;
    out_rec_d   = out_rec_q;
    if (xfer) begin
      out_valid_d      = 1'b1;
      out_rec_d.code   = code_fix;
      out_rec_d.data   = DATA_W'(extract_data(MAX_COLS'(code_fix), COLS));
      out_rec_d.err    = corrected;
      out_rec_d.uncorr = uncorr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rec_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rec_q   <= out_rec_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_code   = out_rec_q.code;
  assign out_data   = out_rec_q.data;
  assign out_err    = out_rec_q.err;
  assign out_uncorr = out_rec_q.uncorr;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted words that needed a bit flip
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xfer && corrected && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
